trap_sequencer: RTL and testbench
=================================

# trap_sequencer

- Sequences trap entry and return for the 5-stage pipeline.
- Consumes the fetch- and execute-stage exception codes and selects the older one.
- Captures the trap CSRs (mepc/mcause/mtval), flushes the pipeline, redirects fetch to the trap vector, and returns on `mret`.
- Owns the `i_reset_permission` / `i_trap_permission` privilege levels that the exception-signal logic consumes.
- Sits beside the hazard unit; its flush/redirect outputs are ORed into the existing flush and PC-select paths.

## Interface
- P_TRAP_VECTOR, 32'h0000_0000, handler entry PC (region pc[20:18]=3'b000).
- P_CNT_W, 8, width of the saturating trap counter.
- Clock/reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_exception_code_f  in  4  fetch-stage code (`NO_E` = none).
- i_exception_code_e  in  4  execute-stage code.
- i_pc_f  in  32  fetch PC.
- i_pc_e  in  32  execute PC.
- i_alu_out_e  in  32  execute effective address.
- i_branch_taken_e  in  1  a branch or jump in E redirects fetch this cycle.
- i_mret_e  in  1  `mret` is in E.
- o_flush_fd, o_flush_de, o_flush_em  out  1 each  pipeline register flushes.
- o_redirect_valid  out  1  PC mux selects o_redirect_pc.
- o_redirect_pc  out  32  redirect target.
- o_csr_we  out  1  write mepc/mcause/mtval this cycle.
- o_mepc, o_mcause, o_mtval  out  32 each  captured trap CSR values.
- o_reset_permission  out  1  core is in the boot region.
- o_trap_permission  out  1  core is in the handler.
- o_halt  out  1  double fault; core frozen.
- o_trap_count  out  P_CNT_W  number of trap entries, saturating.

## Operation
- States: BOOT, RUN, FLUSH, REDIRECT, TRAP, HALT. Reset enters BOOT.
- Event selection, evaluated each cycle:
  - If i_exception_code_e != `NO_E`, the execute-stage exception is selected: cause = code_e, epc = i_pc_e, tval = i_alu_out_e.
  - Otherwise, if i_exception_code_f != `NO_E` and !i_branch_taken_e, the fetch-stage exception is selected: cause = code_f, epc = i_pc_f, tval = i_pc_f.
  - A fetch exception in the same cycle as i_branch_taken_e is on the wrong path and is discarded.
- Transitions:
  - BOOT: any selected exception → HALT. Otherwise, i_pc_f[20:18]==3'b010 → RUN.
  - RUN: selected exception → FLUSH; latch cause, epc and tval on the transition edge.
  - FLUSH (1 cycle): always → REDIRECT.
  - REDIRECT (1 cycle): always → TRAP.
  - TRAP: selected exception → HALT; exception wins over a simultaneous i_mret_e. Otherwise, i_mret_e → RUN.
  - HALT: held until reset.
- Moore outputs by state:
  - BOOT: o_reset_permission=1.
  - FLUSH: o_flush_fd, o_flush_de, o_flush_em = 1; o_csr_we=1.
  - REDIRECT: o_redirect_valid=1, o_redirect_pc=P_TRAP_VECTOR, o_flush_fd=1, o_trap_permission=1.
  - TRAP: o_trap_permission=1.
  - HALT: all three flushes held at 1; o_halt=1.
- `mret` return (Mealy): in TRAP with i_mret_e and no exception, assert o_redirect_valid=1, o_redirect_pc=o_mepc, o_flush_fd=1, o_flush_de=1 in the same cycle. The handler adjusts mepc before returning.
- Trap CSRs:
  - o_mcause = {28'b0, cause}.
  - o_mepc, o_mcause, o_mtval change only on the RUN→FLUSH edge and hold otherwise.
- o_trap_count increments on each RUN→FLUSH edge and saturates at all-ones.

## Timing
- Reset values:
  - State BOOT, o_reset_permission=1.
  - All other single-bit outputs 0.
  - o_mepc, o_mcause, o_mtval, o_redirect_pc and o_trap_count all 0.
- Trap entry latency: exception sampled at edge N; FLUSH during cycle N+1; REDIRECT during N+2; handler instruction at P_TRAP_VECTOR in F during N+3.
- o_trap_permission rises at the start of REDIRECT and falls on the edge following the accepted `mret`.
- Exceptions arriving during FLUSH or REDIRECT are ignored; those stages are being killed.
- Reset is asynchronous mid-trap: any state goes to BOOT immediately. CSRs and the counter clear.

## Structure
- Exception codes (`NO_E`, `E_*`), the region encodings (000 vector, 001 reset, 010 text) and the state encodings belong in Constants.vh.
- Sub-module trap_cause_select is the natural split: combinational priority/valid/cause/epc/tval selection. The FSM and CSR registers live in trap_sequencer.

## Test plan
- Reset released with i_pc_f=32'h0004_0000, then 32'h0008_0000 → o_reset_permission stays 1 in BOOT, then 0 one edge after the text-region PC; state RUN.
- In RUN, code_e=`E_LOAD_ACCESS_FAULT`, i_pc_e=32'h0008_0010, i_alu_out_e=32'h0000_0040 → FLUSH with o_csr_we=1. Next cycle o_redirect_pc=P_TRAP_VECTOR, and o_mepc=32'h0008_0010, o_mtval=32'h40, o_trap_count=1.
- Same cycle code_f=`E_ILLEGAL_INSTR` and code_e=`E_STORE_ADDR_MISALIGNED` → o_mcause = store-misaligned code, o_mepc = i_pc_e.
- code_f=`E_FETCH_ADDR_MISALIGNED` with i_branch_taken_e=1 → no state change, no flush. Same code without the branch → trap with o_mtval=i_pc_f.
- In TRAP, i_mret_e=1 → same-cycle o_redirect_valid=1, o_redirect_pc=o_mepc; RUN next cycle; o_trap_permission=0.
- In TRAP, exception together with i_mret_e → HALT, o_halt=1, flushes held. Later i_rst_n=0 mid-HALT → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: exception codes, PC region
// encodings, FSM states and the selected-trap-event record.
package trap_sequencer_pkg;

  // Exception codes as carried down the pipeline. NO_E marks "nothing pending".
  localparam logic [3:0] E_FETCH_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] E_FETCH_ACCESS_FAULT    = 4'd1;
  localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
  localparam logic [3:0] E_BREAKPOINT            = 4'd3;
  localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd5;
  localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd6;
  localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'd7;
  localparam logic [3:0] E_ECALL                 = 4'd11;
  localparam logic [3:0] NO_E                    = 4'd15;

  // Memory regions are identified by pc[20:18].
  localparam logic [2:0] REGION_VECTOR = 3'b000;
  localparam logic [2:0] REGION_RESET  = 3'b001;
  localparam logic [2:0] REGION_TEXT   = 3'b010;

  // Default handler entry and counter width.
  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int          TRAP_CNT_W_DEFAULT  = 8;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_TRAP     = 3'd4,
    ST_HALT     = 3'd5
  } state_e;

  // The one exception chosen this cycle, with its CSR payload.
  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [31:0] tval;
  } trap_event_t;

  function automatic logic is_exception(input logic [3:0] code);
    return code != NO_E;
  endfunction

  function automatic logic [2:0] pc_region(input logic [31:0] pc);
    return pc[20:18];
  endfunction

endpackage

// File: rtl/trap_cause_select.sv
// Picks the oldest live exception between the execute and fetch stages and
// produces the cause/epc/tval that would be captured if a trap is taken.
module trap_cause_select
  import trap_sequencer_pkg::*;
(
  input  logic [3:0]  i_exception_code_f,
  input  logic [3:0]  i_exception_code_e,
  input  logic [31:0] i_pc_f,
  input  logic [31:0] i_pc_e,
  input  logic [31:0] i_alu_out_e,
  input  logic        i_branch_taken_e,
  output trap_event_t o_event
);

  // Execute is older than fetch so it wins; a fetch fault behind a taken
  // branch is on the wrong path and never becomes a trap.
  always_comb begin
    o_event.valid = 1'b0;
    o_event.cause = NO_E;
    o_event.epc   = 32'h0;
    o_event.tval  = 32'h0;
    if (is_exception(i_exception_code_e)) begin
      o_event.valid = 1'b1;
      o_event.cause = i_exception_code_e;
      o_event.epc   = i_pc_e;
      o_event.tval  = i_alu_out_e;
    end else if (is_exception(i_exception_code_f) && !i_branch_taken_e) begin
      o_event.valid = 1'b1;
      o_event.cause = i_exception_code_f;
      o_event.epc   = i_pc_f;
      o_event.tval  = i_pc_f;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer for the 5-stage pipeline: captures the trap
// CSRs, flushes, redirects fetch to the handler, returns on mret and
// freezes the core on a double fault. Outputs are ORed into the hazard
// unit's flush and PC-select paths.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [31:0] P_TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
  parameter int          P_CNT_W       = TRAP_CNT_W_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [3:0]         i_exception_code_f,
  input  logic [3:0]         i_exception_code_e,
  input  logic [31:0]        i_pc_f,
  input  logic [31:0]        i_pc_e,
  input  logic [31:0]        i_alu_out_e,
  input  logic               i_branch_taken_e,
  input  logic               i_mret_e,
  output logic               o_flush_fd,
  output logic               o_flush_de,
  output logic               o_flush_em,
  output logic               o_redirect_valid,
  output logic [31:0]        o_redirect_pc,
  output logic               o_csr_we,
  output logic [31:0]        o_mepc,
  output logic [31:0]        o_mcause,
  output logic [31:0]        o_mtval,
  output logic               o_reset_permission,
  output logic               o_trap_permission,
  output logic               o_halt,
  output logic [P_CNT_W-1:0] o_trap_count
);

  localparam logic [P_CNT_W-1:0] CNT_MAX = {P_CNT_W{1'b1}};
  localparam logic [P_CNT_W-1:0] CNT_ONE = {{(P_CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [31:0]         mepc_q, mepc_d;
  logic [31:0]         mcause_q, mcause_d;
  logic [31:0]         mtval_q, mtval_d;
  logic [P_CNT_W-1:0]  count_q, count_d;

  trap_event_t         trap_evt;
  logic                take_trap;
  logic                mret_accept;

  trap_cause_select u_cause_select (
    .i_exception_code_f (i_exception_code_f),
    .i_exception_code_e (i_exception_code_e),
    .i_pc_f             (i_pc_f),
    .i_pc_e             (i_pc_e),
    .i_alu_out_e        (i_alu_out_e),
    .i_branch_taken_e   (i_branch_taken_e),
    .o_event            (trap_evt)
  );

  // Next-state logic; FLUSH and REDIRECT ignore exceptions because the
  // stages that raised them are being killed.
  always_comb begin
    state_d     = state_q;
    take_trap   = 1'b0;
    mret_accept = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (trap_evt.valid) begin
          state_d = ST_HALT;
        end else if (pc_region(i_pc_f) == REGION_TEXT) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (trap_evt.valid) begin
          state_d   = ST_FLUSH;
          take_trap = 1'b1;
        end
      end
      ST_FLUSH:    state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_TRAP;
      ST_TRAP: begin
        if (trap_evt.valid) begin
          state_d = ST_HALT;
        end else if (i_mret_e) begin
          state_d     = ST_RUN;
          mret_accept = 1'b1;
        end
      end
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_HALT;
    endcase
  end

  // CSR capture and saturating trap counter, both only on trap entry.
  always_comb begin
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    count_d  = count_q;
    if (take_trap) begin
      mepc_d   = trap_evt.epc;
      mcause_d = {28'b0, trap_evt.cause};
      mtval_d  = trap_evt.tval;
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  // Moore outputs per state plus the same-cycle mret redirect.
  always_comb begin
    o_flush_fd         = 1'b0;
    o_flush_de         = 1'b0;
    o_flush_em         = 1'b0;
    o_redirect_valid   = 1'b0;
    o_redirect_pc      = 32'h0;
    o_csr_we           = 1'b0;
    o_reset_permission = 1'b0;
    o_trap_permission  = 1'b0;
    o_halt             = 1'b0;
    case (state_q)
      ST_BOOT: begin
        o_reset_permission = 1'b1;
      end
      ST_FLUSH: begin
        o_flush_fd = 1'b1;
        o_flush_de = 1'b1;
        o_flush_em = 1'b1;
        o_csr_we   = 1'b1;
      end
      ST_REDIRECT: begin
        o_redirect_valid  = 1'b1;
        o_redirect_pc     = P_TRAP_VECTOR;
        o_flush_fd        = 1'b1;
        o_trap_permission = 1'b1;
      end
      ST_TRAP: begin
        o_trap_permission = 1'b1;
        if (mret_accept) begin
          o_redirect_valid = 1'b1;
          o_redirect_pc    = mepc_q;
          o_flush_fd       = 1'b1;
          o_flush_de       = 1'b1;
        end
      end
      ST_HALT: begin
        o_flush_fd = 1'b1;
        o_flush_de = 1'b1;
        o_flush_em = 1'b1;
        o_halt     = 1'b1;
      end
      default: begin
        o_halt = 1'b0;
      end
    endcase
  end

  // State and CSR registers; reset clears everything back to BOOT at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_BOOT;
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
      mtval_q  <= 32'h0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      count_q  <= count_d;
    end
  end

  assign o_mepc       = mepc_q;
  assign o_mcause     = mcause_q;
  assign o_mtval      = mtval_q;
  assign o_trap_count = count_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: a driver applies directed and random
// cycles and pushes the reference model's expected outputs; a monitor pops
// and compares on the falling edge.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0000;
  localparam int          CNT_W       = 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [3:0]        i_exception_code_f, i_exception_code_e;
  logic [31:0]       i_pc_f, i_pc_e, i_alu_out_e;
  logic              i_branch_taken_e, i_mret_e;
  logic              o_flush_fd, o_flush_de, o_flush_em;
  logic              o_redirect_valid;
  logic [31:0]       o_redirect_pc;
  logic              o_csr_we;
  logic [31:0]       o_mepc, o_mcause, o_mtval;
  logic              o_reset_permission, o_trap_permission, o_halt;
  logic [CNT_W-1:0]  o_trap_count;

  trap_sequencer #(.P_TRAP_VECTOR(TRAP_VECTOR), .P_CNT_W(CNT_W)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_exception_code_f (i_exception_code_f),
    .i_exception_code_e (i_exception_code_e),
    .i_pc_f             (i_pc_f),
    .i_pc_e             (i_pc_e),
    .i_alu_out_e        (i_alu_out_e),
    .i_branch_taken_e   (i_branch_taken_e),
    .i_mret_e           (i_mret_e),
    .o_flush_fd         (o_flush_fd),
    .o_flush_de         (o_flush_de),
    .o_flush_em         (o_flush_em),
    .o_redirect_valid   (o_redirect_valid),
    .o_redirect_pc      (o_redirect_pc),
    .o_csr_we           (o_csr_we),
    .o_mepc             (o_mepc),
    .o_mcause           (o_mcause),
    .o_mtval            (o_mtval),
    .o_reset_permission (o_reset_permission),
    .o_trap_permission  (o_trap_permission),
    .o_halt             (o_halt),
    .o_trap_count       (o_trap_count)
  );

  always #5 i_clk = ~i_clk;

  // Expected output vector for one cycle; flush is {fd, de, em}.
  typedef struct {
    logic [2:0]  flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        csr_we;
    logic [31:0] mepc, mcause, mtval;
    logic        reset_perm, trap_perm, halt;
    logic [7:0]  count;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  logic [3:0] codes [9] = '{E_FETCH_ADDR_MISALIGNED, E_FETCH_ACCESS_FAULT,
                            E_ILLEGAL_INSTR, E_BREAKPOINT, E_LOAD_ADDR_MISALIGNED,
                            E_LOAD_ACCESS_FAULT, E_STORE_ADDR_MISALIGNED,
                            E_STORE_ACCESS_FAULT, E_ECALL};

  // Reference model: the core is either booting, running, halted, in the
  // handler, or counting down the two cycles of trap entry.
  bit          m_in_boot = 1'b1;
  bit          m_halted  = 1'b0;
  bit          m_handler = 1'b0;
  int          m_entry_left = 0;
  logic [31:0] m_mepc = 0, m_mcause = 0, m_mtval = 0;
  int          m_count = 0;
  int          halt_cycles = 0;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks_total++;
    if (act === expv) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("flush_fd", 32'(o_flush_fd), 32'(e.flush[2]));
    checkField("flush_de", 32'(o_flush_de), 32'(e.flush[1]));
    checkField("flush_em", 32'(o_flush_em), 32'(e.flush[0]));
    checkField("redirect_valid", 32'(o_redirect_valid), 32'(e.redirect_valid));
    checkField("redirect_pc", o_redirect_pc, e.redirect_pc);
    checkField("csr_we", 32'(o_csr_we), 32'(e.csr_we));
    checkField("mepc", o_mepc, e.mepc);
    checkField("mcause", o_mcause, e.mcause);
    checkField("mtval", o_mtval, e.mtval);
    checkField("reset_permission", 32'(o_reset_permission), 32'(e.reset_perm));
    checkField("trap_permission", 32'(o_trap_permission), 32'(e.trap_perm));
    checkField("halt", 32'(o_halt), 32'(e.halt));
    checkField("trap_count", 32'(o_trap_count), 32'(e.count));
  endtask

  // Drive one cycle, predict its outputs, then advance the model past the edge.
  task automatic applyStimulus(input logic rst_n, input logic [3:0] code_f, input logic [3:0] code_e,
                               input logic [31:0] pc_f, input logic [31:0] pc_e,
                               input logic [31:0] alu, input logic br, input logic mret);
    exp_t        e;
    logic        sel;
    logic [3:0]  cause;
    logic [31:0] epc, tval;
    @(posedge i_clk);
    #1;
    i_rst_n = rst_n; i_exception_code_f = code_f; i_exception_code_e = code_e;
    i_pc_f = pc_f; i_pc_e = pc_e; i_alu_out_e = alu; i_branch_taken_e = br; i_mret_e = mret;

    if (!rst_n) begin
      m_in_boot = 1; m_halted = 0; m_handler = 0; m_entry_left = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_count = 0;
    end

    sel = 0; cause = 0; epc = 0; tval = 0;
    if (code_e != NO_E) begin
      sel = 1; cause = code_e; epc = pc_e; tval = alu;
    end else if (code_f != NO_E && !br) begin
      sel = 1; cause = code_f; epc = pc_f; tval = pc_f;
    end

    e.flush = 3'b000; e.redirect_valid = 0; e.redirect_pc = 0; e.csr_we = 0;
    e.mepc = m_mepc; e.mcause = m_mcause; e.mtval = m_mtval;
    e.reset_perm = 0; e.trap_perm = 0; e.halt = 0; e.count = 8'(m_count);
    if (m_halted) begin
      e.flush = 3'b111; e.halt = 1;
    end else if (m_entry_left == 2) begin
      e.flush = 3'b111; e.csr_we = 1;
    end else if (m_entry_left == 1) begin
      e.redirect_valid = 1; e.redirect_pc = TRAP_VECTOR; e.flush = 3'b100; e.trap_perm = 1;
    end else if (m_in_boot) begin
      e.reset_perm = 1;
    end else if (m_handler) begin
      e.trap_perm = 1;
      if (mret && !sel) begin
        e.redirect_valid = 1; e.redirect_pc = m_mepc; e.flush = 3'b110;
      end
    end
    exp_q.push_back(e);

    if (rst_n) begin
      if (m_halted) begin
        halt_cycles++;
      end else if (m_entry_left == 2) begin
        m_entry_left = 1;
      end else if (m_entry_left == 1) begin
        m_entry_left = 0; m_handler = 1;
      end else if (m_in_boot) begin
        if (sel) m_halted = 1;
        else if (pc_f[20:18] == 3'b010) m_in_boot = 0;
      end else if (m_handler) begin
        if (sel) m_halted = 1;
        else if (mret) m_handler = 0;
      end else if (sel) begin
        m_entry_left = 2;
        m_mepc = epc; m_mcause = {28'b0, cause}; m_mtval = tval;
        if (m_count < 255) m_count++;
      end
    end else begin
      halt_cycles = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      applyStimulus(1, NO_E, NO_E, 32'h0008_0100, 32'h0008_00F8, 32'h0, 0, 0);
  endtask

  function automatic logic [31:0] randPc();
    logic [2:0] r;
    r = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom_range(0, 7));
    return {11'($urandom), r, 18'($urandom)};
  endfunction

  function automatic logic [3:0] randCode(input int one_in);
    return ($urandom_range(1, one_in) == 1) ? codes[$urandom_range(0, 8)] : NO_E;
  endfunction

  // Monitor: compare every presented output vector against the scoreboard.
  initial begin
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    i_rst_n = 0; i_exception_code_f = NO_E; i_exception_code_e = NO_E;
    i_pc_f = 0; i_pc_e = 0; i_alu_out_e = 0; i_branch_taken_e = 0; i_mret_e = 0;

    // Boot from the reset region, then enter the text region.
    applyStimulus(0, NO_E, NO_E, 32'h0004_0000, 0, 0, 0, 0);
    applyStimulus(0, NO_E, NO_E, 32'h0004_0000, 0, 0, 0, 0);
    applyStimulus(1, NO_E, NO_E, 32'h0004_0000, 0, 0, 0, 0);
    applyStimulus(1, NO_E, NO_E, 32'h0004_0004, 0, 0, 0, 0);
    applyStimulus(1, NO_E, NO_E, 32'h0008_0000, 0, 0, 0, 0);
    idle(2);

    // Load access fault from execute, then mret back.
    applyStimulus(1, NO_E, E_LOAD_ACCESS_FAULT, 32'h0008_0014, 32'h0008_0010, 32'h0000_0040, 0, 0);
    idle(3);
    applyStimulus(1, NO_E, NO_E, 32'h0000_0010, 0, 0, 0, 1);
    idle(2);

    // Execute beats fetch when both fault together.
    applyStimulus(1, E_ILLEGAL_INSTR, E_STORE_ADDR_MISALIGNED, 32'h0008_0024, 32'h0008_0020, 32'h0000_1003, 0, 0);
    idle(3);
    applyStimulus(1, NO_E, NO_E, 32'h0000_0020, 0, 0, 0, 1);
    idle(1);

    // Wrong-path fetch fault is dropped; the same fault on the right path traps.
    applyStimulus(1, E_FETCH_ADDR_MISALIGNED, NO_E, 32'h0008_0031, 32'h0008_0028, 32'h0008_0031, 1, 0);
    idle(1);
    applyStimulus(1, E_FETCH_ADDR_MISALIGNED, NO_E, 32'h0008_0032, 32'h0008_002C, 0, 0, 0);
    idle(3);

    // Exception alongside mret in the handler is a double fault; reset mid-halt.
    applyStimulus(1, NO_E, E_ECALL, 32'h0000_0030, 32'h0000_002C, 0, 0, 1);
    idle(3);
    applyStimulus(0, NO_E, NO_E, 32'h0004_0000, 0, 0, 0, 0);
    applyStimulus(0, NO_E, NO_E, 32'h0004_0000, 0, 0, 0, 0);

    // Drive the trap counter past saturation.
    applyStimulus(1, NO_E, NO_E, 32'h0008_0000, 0, 0, 0, 0);
    for (int k = 0; k < 260; k++) begin
      applyStimulus(1, NO_E, codes[$urandom_range(0, 8)], 32'h0008_0200, 32'h0008_0000 + 32'(k*4),
                    $urandom, 0, 0);
      idle(3);
      applyStimulus(1, NO_E, NO_E, 32'h0000_0040, 0, 0, 0, 1);
    end

    // Random traffic with occasional resets to escape halts.
    applyStimulus(0, NO_E, NO_E, 32'h0004_0000, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      if (halt_cycles > 3 || $urandom_range(0, 299) == 0)
        applyStimulus(0, NO_E, NO_E, randPc(), $urandom, $urandom, 0, 0);
      else
        applyStimulus(1, randCode(10), randCode(12), randPc(), $urandom, $urandom,
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    @(negedge i_clk);
    @(negedge i_clk);
    checks_total++;
    if (exp_q.size() == 0) checks_passed++;
    else $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
